// File: rtl/vga_timing_pkg.sv
// Shared raster constants and sizing helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;

  localparam int unsigned DEF_SCREEN_H = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return active + front + sync + back;
  endfunction

  // A counter must be at least one bit even when it only ever holds 0..1.
  function automatic int unsigned calc_width(input int unsigned count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// Divides the system clock down to a one-clk pixel strobe (clk_mhz / pixel_mhz).
// With a ratio of 1 the strobe is simply held high whenever reset is released.
module pixel_strobe_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned clk_mhz   = 50,
  parameter int unsigned pixel_mhz = 25
) (
  input  logic clk,
  input  logic rst,
  output logic pixel_en
);

  localparam int unsigned DIV = clk_mhz / pixel_mhz;

  if ((clk_mhz % pixel_mhz) != 0) begin : g_bad_ratio
    $error("pixel_strobe_gen: clk_mhz must be an integer multiple of pixel_mhz");
  end

  if (DIV == 1) begin : g_div1
    assign pixel_en = rst;
  end else begin : g_divn
    localparam int unsigned CW = calc_width(DIV);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign pixel_en = (r_cnt == C_LAST);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters and registered sync/active decode for a VGA display.
// Define VGA_TIMING_GEN_OUT_REG_EN to delay all decoded outputs by one pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned clk_mhz       = 50,
  parameter int unsigned pixel_mhz     = 25,
  parameter int unsigned screen_width  = DEF_SCREEN_W,
  parameter int unsigned screen_height = DEF_SCREEN_H,
  parameter int unsigned h_front       = DEF_H_FRONT,
  parameter int unsigned h_sync        = DEF_H_SYNC,
  parameter int unsigned h_back        = DEF_H_BACK,
  parameter int unsigned v_front       = DEF_V_FRONT,
  parameter int unsigned v_sync        = DEF_V_SYNC,
  parameter int unsigned v_back        = DEF_V_BACK,
  parameter int unsigned w_x           = $clog2(screen_width),
  parameter int unsigned w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pixel_en,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL = calc_total(screen_width, h_front, h_sync, h_back);
  localparam int unsigned V_TOTAL = calc_total(screen_height, v_front, v_sync, v_back);
  localparam int unsigned HW      = calc_width(H_TOTAL);
  localparam int unsigned VW      = calc_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACTIVE   = HW'(screen_width);
  localparam logic [VW-1:0] V_ACTIVE   = VW'(screen_height);
  localparam logic [HW-1:0] HS_START   = HW'(screen_width + h_front);
  localparam logic [HW-1:0] HS_END     = HW'(screen_width + h_front + h_sync);
  localparam logic [VW-1:0] VS_START   = VW'(screen_height + v_front);
  localparam logic [VW-1:0] VS_END     = VW'(screen_height + v_front + v_sync);

  logic           w_pixel_en;
  logic [HW-1:0]  r_hcnt, w_hcnt_nxt;
  logic [VW-1:0]  r_vcnt, w_vcnt_nxt;
  logic           w_hsync_nxt, w_vsync_nxt, w_display_nxt, w_frame_nxt;
  logic [w_x-1:0] w_x_nxt;
  logic [w_y-1:0] w_y_nxt;

  logic           r_hsync, r_vsync, r_display_on;
  logic [w_x-1:0] r_x;
  logic [w_y-1:0] r_y;

  pixel_strobe_gen #(
    .clk_mhz   (clk_mhz),
    .pixel_mhz (pixel_mhz)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .pixel_en (w_pixel_en)
  );

  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_vcnt_nxt = r_vcnt;
    if (w_pixel_en) begin
      if (r_hcnt == H_LAST) begin
        w_hcnt_nxt = '0;
        w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
      end else begin
        w_hcnt_nxt = r_hcnt + HW'(1);
      end
    end
  end

  // Decode from the next counter values so the registered outputs line up with the counters.
  always_comb begin
    w_display_nxt = (w_hcnt_nxt < H_ACTIVE) && (w_vcnt_nxt < V_ACTIVE);
    w_hsync_nxt   = !((w_hcnt_nxt >= HS_START) && (w_hcnt_nxt < HS_END));
    w_vsync_nxt   = !((w_vcnt_nxt >= VS_START) && (w_vcnt_nxt < VS_END));
    w_x_nxt       = w_display_nxt ? w_hcnt_nxt[w_x-1:0] : '0;
    w_y_nxt       = w_display_nxt ? w_vcnt_nxt[w_y-1:0] : '0;
    w_frame_nxt   = w_pixel_en && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt       <= H_LAST;
      r_vcnt       <= V_LAST;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_display_on <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_hcnt       <= w_hcnt_nxt;
      r_vcnt       <= w_vcnt_nxt;
      r_hsync      <= w_hsync_nxt;
      r_vsync      <= w_vsync_nxt;
      r_display_on <= w_display_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
    end
  end

  assign pixel_en = w_pixel_en;

`ifdef VGA_TIMING_GEN_OUT_REG_EN
  logic           r2_hsync, r2_vsync, r2_display_on, r2_frame_start;
  logic [w_x-1:0] r2_x;
  logic [w_y-1:0] r2_y;

  // The delayed frame pulse fires on the strobe that moves the delayed view onto (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_hsync       <= 1'b1;
      r2_vsync       <= 1'b1;
      r2_display_on  <= 1'b0;
      r2_x           <= '0;
      r2_y           <= '0;
      r2_frame_start <= 1'b0;
    end else begin
      r2_frame_start <= w_pixel_en && (r_hcnt == '0) && (r_vcnt == '0);
      if (w_pixel_en) begin
        r2_hsync      <= r_hsync;
        r2_vsync      <= r_vsync;
        r2_display_on <= r_display_on;
        r2_x          <= r_x;
        r2_y          <= r_y;
      end
    end
  end

  assign hsync       = r2_hsync;
  assign vsync       = r2_vsync;
  assign display_on  = r2_display_on;
  assign x           = r2_x;
  assign y           = r2_y;
  assign frame_start = r2_frame_start;
`else
  logic r_frame_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_nxt;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_frame_start;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 (div 2), div 1, and a small raster (div 3)
// checked against an arithmetic raster model, a boundary vector table and edge timings.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_TIMING_GEN_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic        pe;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  typedef struct {
    int div;
    int sw, hf, hs, hb;
    int sh, vf, vs, vb;
  } timing_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_pe, a_hs, a_vs, a_de, a_fs;
  logic [9:0] a_x;
  logic [8:0] a_y;
  logic       b_pe, b_hs, b_vs, b_de, b_fs;
  logic [9:0] b_x;
  logic [8:0] b_y;
  logic       c_pe, c_hs, c_vs, c_de, c_fs;
  logic [5:0] c_x;
  logic [4:0] c_y;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pixel_en(a_pe), .hsync(a_hs), .vsync(a_vs),
    .display_on(a_de), .x(a_x), .y(a_y), .frame_start(a_fs)
  );

  vga_timing_gen #(.clk_mhz(25), .pixel_mhz(25)) u_div1 (
    .clk(clk), .rst(rst), .pixel_en(b_pe), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .x(b_x), .y(b_y), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .clk_mhz(75), .pixel_mhz(25), .screen_width(40), .screen_height(20),
    .h_front(4), .h_sync(8), .h_back(6), .v_front(3), .v_sync(2), .v_back(5)
  ) u_small (
    .clk(clk), .rst(rst), .pixel_en(c_pe), .hsync(c_hs), .vsync(c_vs),
    .display_on(c_de), .x(c_x), .y(c_y), .frame_start(c_fs)
  );

  timing_t t_def, t_d1, t_sml;
  int checks = 0;
  int errors = 0;
  int k;
  vec_t tbl[14];
  int tbl_idx;

  int   b_hfall_k, a_hfall_k, a_derise_k, c_fs_k, c_vfall_k;
  logic b_hs_p, a_hs_p, a_de_p, c_fs_p, c_vs_p;

  function automatic obs_t mk(input logic pe, hs, vs, de, fs, input int xv, input int yv);
    obs_t o;
    o.pe = pe; o.hs = hs; o.vs = vs; o.de = de; o.fs = fs;
    o.x = 16'(xv); o.y = 16'(yv);
    return o;
  endfunction

  // Pixels advanced after kk clock edges since release; raster position is (n-1) mod frame.
  function automatic int pixels_after(input timing_t t, input int kk);
    if (kk <= 0) return 0;
    return (t.div == 1) ? kk : kk / t.div;
  endfunction

  function automatic obs_t model(input timing_t t, input int kk, input bit released);
    obs_t o;
    int ne, nep, ht, vt, p, h, v;
    o = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    if (!released) return o;
    o.pe = (t.div == 1) ? 1'b1 : ((kk % t.div) == (t.div - 1));
    ne  = pixels_after(t, kk) - LAT;
    nep = pixels_after(t, kk - 1) - LAT;
    if (ne <= 0) return o;
    ht = t.sw + t.hf + t.hs + t.hb;
    vt = t.sh + t.vf + t.vs + t.vb;
    p  = (ne - 1) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    o.de = (h < t.sw) && (v < t.sh);
    o.hs = !((h >= t.sw + t.hf) && (h < t.sw + t.hf + t.hs));
    o.vs = !((v >= t.sh + t.vf) && (v < t.sh + t.vf + t.vs));
    o.x  = o.de ? 16'(h) : 16'd0;
    o.y  = o.de ? 16'(v) : 16'd0;
    o.fs = (p == 0) && (ne != nep);
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got pe=%0b hs=%0b vs=%0b de=%0b fs=%0b x=%0d y=%0d, expected pe=%0b hs=%0b vs=%0b de=%0b fs=%0b x=%0d y=%0d",
               name, k, act.pe, act.hs, act.vs, act.de, act.fs, act.x, act.y,
               exp.pe, exp.hs, exp.vs, exp.de, exp.fs, exp.x, exp.y);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s k=%0d: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  task automatic check_all(input bit released);
    check_obs("def model",   mk(a_pe, a_hs, a_vs, a_de, a_fs, int'(a_x), int'(a_y)), model(t_def, k, released));
    check_obs("div1 model",  mk(b_pe, b_hs, b_vs, b_de, b_fs, int'(b_x), int'(b_y)), model(t_d1,  k, released));
    check_obs("small model", mk(c_pe, c_hs, c_vs, c_de, c_fs, int'(c_x), int'(c_y)), model(t_sml, k, released));
  endtask

  task automatic reset_trackers();
    b_hfall_k = -1; a_hfall_k = -1; a_derise_k = -1; c_fs_k = -1; c_vfall_k = -1;
    b_hs_p = b_hs; a_hs_p = a_hs; a_de_p = a_de; c_fs_p = c_fs; c_vs_p = c_vs;
  endtask

  task automatic release_reset();
    rst = 1'b1;
    k = 0;
    #1;
    check_all(1'b1);
    reset_trackers();
  endtask

  task automatic run_cycles(input int ncyc, input bit use_tbl);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      k++;
      check_all(1'b1);
      while (use_tbl && tbl_idx < 14 && tbl[tbl_idx].k + LAT * 2 == k) begin
        check_obs("def table", mk(a_pe, a_hs, a_vs, a_de, a_fs, int'(a_x), int'(a_y)), tbl[tbl_idx].exp);
        tbl_idx++;
      end
      if (b_hs_p && !b_hs) begin
        if (b_hfall_k >= 0) check_int("div1 line period clks", k - b_hfall_k, 800);
        b_hfall_k = k;
      end
      if (!b_hs_p && b_hs && b_hfall_k >= 0) check_int("div1 hsync low clks", k - b_hfall_k, 96);
      if (a_hs_p && !a_hs) a_hfall_k = k;
      if (!a_hs_p && a_hs && a_hfall_k >= 0) check_int("def hsync low clks", k - a_hfall_k, 192);
      if (!a_de_p && a_de) a_derise_k = k;
      if (a_de_p && !a_de && a_derise_k >= 0) check_int("def display run clks", k - a_derise_k, 1280);
      if (!c_fs_p && c_fs) begin
        if (c_fs_k >= 0) check_int("small frame period clks", k - c_fs_k, 5220);
        c_fs_k = k;
      end
      if (c_vs_p && !c_vs) begin
        if (c_fs_k >= 0) check_int("small vsync start clks", k - c_fs_k, 4002);
        c_vfall_k = k;
      end
      if (!c_vs_p && c_vs && c_vfall_k >= 0) check_int("small vsync low clks", k - c_vfall_k, 348);
      b_hs_p = b_hs; a_hs_p = a_hs; a_de_p = a_de; c_fs_p = c_fs; c_vs_p = c_vs;
    end
  endtask

  initial begin
    t_def = '{div:2, sw:640, hf:16, hs:96, hb:48, sh:480, vf:10, vs:2, vb:33};
    t_d1  = '{div:1, sw:640, hf:16, hs:96, hb:48, sh:480, vf:10, vs:2, vb:33};
    t_sml = '{div:3, sw:40,  hf:4,  hs:8,  hb:6,  sh:20,  vf:3,  vs:2, vb:5};

    //              k     pe    hs    vs    de    fs    x    y
    tbl[0]  = '{1,    mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[1]  = '{2,    mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0,   0)};
    tbl[2]  = '{3,    mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0,   0)};
    tbl[3]  = '{4,    mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1,   0)};
    tbl[4]  = '{1280, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 639, 0)};
    tbl[5]  = '{1281, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 639, 0)};
    tbl[6]  = '{1282, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[7]  = '{1313, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[8]  = '{1314, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[9]  = '{1505, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[10] = '{1506, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[11] = '{1600, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0)};
    tbl[12] = '{1602, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,   1)};
    tbl[13] = '{1604, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1,   1)};
    tbl_idx = 0;

    // Clock/reset
    k = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all(1'b0);
    release_reset();

    // Power-on run: two small frames, many default lines, boundary table
    run_cycles(11000, 1'b1);
    check_int("table entries reached", tbl_idx, 14);

    // Random asynchronous resets mid-frame
    for (int r = 0; r < 3; r++) begin
      run_cycles($urandom_range(1500, 5000), 1'b0);
      #2 rst = 1'b0;
      #1 check_all(1'b0);
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        check_all(1'b0);
      end
      release_reset();
      run_cycles(6000, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
